// File: rtl/mem_arbiter_if.sv
// Bundle of the per-port request/response signals and the downstream
// memory bus seen by mem_arbiter. The master modport is the arbiter side,
// the slave modport is the environment (requestors plus memory).
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Requestor side
  logic [NUM_PORTS-1:0]            port_read;
  logic [NUM_PORTS-1:0]            port_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
  logic [NUM_PORTS*BEW-1:0]        port_byte_enable;
  logic [NUM_PORTS-1:0]            port_resp;
  logic [DATA_WIDTH-1:0]           port_rdata;

  // Downstream memory side
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [BEW-1:0]                  mem_byte_enable;
  logic                            mem_read;
  logic                            mem_write;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  logic [GW-1:0]                   grant_id;

  modport master (
    input  port_read, port_write, port_address, port_wdata, port_byte_enable,
    input  mem_resp, mem_rdata,
    output port_resp, port_rdata,
    output mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write,
    output grant_id
  );

  modport slave (
    output port_read, port_write, port_address, port_wdata, port_byte_enable,
    output mem_resp, mem_rdata,
    input  port_resp, port_rdata,
    input  mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write,
    input  grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS requestors onto one memory bus.
// One transaction in flight at a time: IDLE picks a winner and latches its
// request, BUSY holds the downstream request until mem_resp, DONE pulses the
// winner's completion and advances the priority pointer past it.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,   // synchronous, active-low
  mem_arbiter_if.master bus
);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BEW-1:0]        be_q, be_d;
  logic [NUM_PORTS-1:0]  resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Per-port views of the flattened request buses
  logic [NUM_PORTS-1:0]  req;
  logic [ADDR_WIDTH-1:0] addr_s  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_s [NUM_PORTS];
  logic [BEW-1:0]        be_s    [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req[gi]     = bus.port_read[gi] | bus.port_write[gi];
      assign addr_s[gi]  = bus.port_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_s[gi] = bus.port_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign be_s[gi]    = bus.port_byte_enable[gi*BEW +: BEW];
    end
  endgenerate

  // Round-robin search: first requesting port at or after ptr, wrapping
  logic          found;
  logic [GW-1:0] winner;
  int            idx;
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  // Next-state and next-output logic; everything defaults to hold
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    resp_d  = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          addr_d  = addr_s[winner];
          wdata_d = wdata_s[winner];
          be_d    = be_s[winner];
          // A simultaneous read+write request is issued as a write
          wr_d    = bus.port_write[winner];
          rd_d    = bus.port_read[winner] & ~bus.port_write[winner];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          rdata_d         = bus.mem_rdata;
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          resp_d[grant_q] = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_read        = rd_q;
  assign bus.mem_write       = wr_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.port_resp       = resp_q;
  assign bus.port_rdata      = rdata_q;
  assign bus.grant_id        = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (2 ports, 32-bit). Inputs are driven and
// outputs sampled on the falling edge, half a cycle away from the DUT edge.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    bus.port_read[p]               = rd;
    bus.port_write[p]              = wr;
    bus.port_address[p*32 +: 32]   = a;
    bus.port_wdata[p*32 +: 32]     = d;
    bus.port_byte_enable[p*4 +: 4] = be;
  endtask

  task automatic clear_ports();
    bus.port_read  = '0;
    bus.port_write = '0;
  endtask

  initial begin
    int g;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.port_read        = '0;
    bus.port_write       = '0;
    bus.port_address     = '0;
    bus.port_wdata       = '0;
    bus.port_byte_enable = '0;
    bus.mem_resp         = 1'b0;
    bus.mem_rdata        = '0;

    // Reset state
    tick(); tick(); tick();
    check("rst_mem_read",  bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr",  bus.mem_address, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_be",    bus.mem_byte_enable, 0);
    check("rst_port_resp", bus.port_resp, 0);
    check("rst_rdata",     bus.port_rdata, 0);
    check("rst_grant",     bus.grant_id, 0);
    rst = 1'b1;

    // Idle with no requests stays quiet
    tick();
    check("idle_mem_read", bus.mem_read, 0);

    // Single read from port 0, response after 3 busy cycles
    set_port(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    check("rd_mem_read",  bus.mem_read, 1);
    check("rd_mem_write", bus.mem_write, 0);
    check("rd_mem_addr",  bus.mem_address, 64'h1000);
    check("rd_grant",     bus.grant_id, 0);
    tick();
    check("rd_hold1", bus.mem_read, 1);
    check("rd_resp_early", bus.port_resp, 0);
    tick();
    check("rd_hold2", bus.mem_address, 64'h1000);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_resp = 1'b0;
    clear_ports();
    check("rd_port_resp", bus.port_resp, 2'b01);
    check("rd_rdata",     bus.port_rdata, 64'hDEAD_BEEF);
    check("rd_mem_read_off", bus.mem_read, 0);
    tick();
    check("rd_resp_pulse", bus.port_resp, 0);
    check("rd_rdata_hold", bus.port_rdata, 64'hDEAD_BEEF);

    // Contention from reset: 0,1,0,1
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
    set_port(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
    for (int r = 0; r < 4; r++) begin
      g = r % 2;
      tick();
      check($sformatf("cont%0d_grant", r), bus.grant_id, 64'(g));
      check($sformatf("cont%0d_addr", r), bus.mem_address, (g == 0) ? 64'hA0 : 64'hB0);
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h100 + 32'(r);
      tick();
      bus.mem_resp = 1'b0;
      if (r == 3) clear_ports();
      check($sformatf("cont%0d_resp", r), bus.port_resp, (g == 0) ? 64'b01 : 64'b10);
      check($sformatf("cont%0d_rdata", r), bus.port_rdata, 64'h100 + 64'(r));
      tick();
      check($sformatf("cont%0d_resp_off", r), bus.port_resp, 0);
    end

    // Write from port 1 (ptr is back at 0)
    set_port(1, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    tick();
    check("wr_mem_write", bus.mem_write, 1);
    check("wr_mem_read",  bus.mem_read, 0);
    check("wr_addr",      bus.mem_address, 64'h2000);
    check("wr_wdata",     bus.mem_wdata, 64'h1234_5678);
    check("wr_be",        bus.mem_byte_enable, 64'b0011);
    check("wr_grant",     bus.grant_id, 1);
    set_port(1, 1'b0, 1'b1, 32'h0000_2000, 32'hFFFF_0000, 4'b1100);
    tick();
    check("wr_wdata_stable", bus.mem_wdata, 64'h1234_5678);
    check("wr_be_stable",    bus.mem_byte_enable, 64'b0011);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    clear_ports();
    check("wr_port_resp", bus.port_resp, 2'b10);
    tick();

    // Address stability while busy (ptr = 0)
    set_port(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    check("stab_addr0", bus.mem_address, 64'h1000);
    set_port(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
    tick();
    check("stab_addr1", bus.mem_address, 64'h1000);
    tick();
    check("stab_addr2", bus.mem_address, 64'h1000);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    clear_ports();
    check("stab_port_resp", bus.port_resp, 2'b01);
    tick();

    // Read+write on the same port is a write (ptr = 1, only port 0 asks)
    set_port(0, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
    tick();
    check("rw_mem_write", bus.mem_write, 1);
    check("rw_mem_read",  bus.mem_read, 0);
    check("rw_grant",     bus.grant_id, 0);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    clear_ports();
    check("rw_port_resp", bus.port_resp, 2'b01);
    tick();

    // Reset two cycles into a port-1 read (ptr = 1 before reset)
    set_port(1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    tick();
    check("rb_grant", bus.grant_id, 1);
    tick();
    check("rb_busy", bus.mem_read, 1);
    rst = 1'b0;
    clear_ports();
    tick();
    check("rb_mem_read", bus.mem_read, 0);
    check("rb_grant_rst", bus.grant_id, 0);
    check("rb_port_resp", bus.port_resp, 0);
    rst = 1'b1;
    bus.mem_resp = 1'b1;
    tick();
    check("rb_late_resp", bus.port_resp, 0);
    check("rb_late_read", bus.mem_read, 0);
    bus.mem_resp = 1'b0;
    tick();
    check("rb_late_resp2", bus.port_resp, 0);
    // ptr was cleared: contention now goes to port 0
    set_port(0, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
    set_port(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
    tick();
    check("rb_ptr_grant", bus.grant_id, 0);
    check("rb_ptr_addr",  bus.mem_address, 64'hA0);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    clear_ports();
    check("rb_ptr_resp", bus.port_resp, 2'b01);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
